// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array controller.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Number of stages from an issued ifmap vector to the last column's result.
    function automatic int unsigned skew_depth(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/valid_skew_pipe.sv
// Enable-gated shift register tracking which in-flight wavefronts carry real vectors.
module valid_skew_pipe #(
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    logic [DEPTH-1:0] q_q;
    logic [DEPTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (q_q << 1) | DEPTH'(din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/systolic_array_controller.sv
// Sequences weight preload, ifmap streaming and pipeline drain for a ROWSxCOLS
// weight-stationary systolic array, with backpressure from the ofmap sink.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [COUNT_WIDTH-1:0]                   cfg_num_vec,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     weight_rd_en,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] weight_rd_addr,
    output logic [ROWS-1:0]                          weight_wen,
    input  logic                                     ifmap_valid,
    output logic                                     ifmap_ready,
    output logic                                     ifmap_zero,
    output logic                                     mac_en,
    output logic [COLS-1:0]                          ofmap_valid,
    input  logic                                     ofmap_ready
);

    localparam int unsigned AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LW    = $clog2(ROWS + 1);
    localparam int unsigned DEPTH = skew_depth(ROWS, COLS);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] num_vec_q, num_vec_d;
    logic [COUNT_WIDTH-1:0] issue_q, issue_d;
    logic [LW-1:0]          load_q, load_d;
    logic [ROWS-1:0]        wen_q, wen_d;
    logic [DEPTH-1:0]       line;
    logic [DEPTH-1:0]       line_next;
    logic                   stall;
    logic                   issue;

    always_comb begin
        state_d        = state_q;
        num_vec_d      = num_vec_q;
        issue_d        = issue_q;
        load_d         = load_q;
        wen_d          = '0;
        weight_rd_en   = 1'b0;
        weight_rd_addr = '0;
        ifmap_ready    = 1'b0;
        ifmap_zero     = 1'b0;
        mac_en         = 1'b0;
        issue          = 1'b0;
        line_next      = line;
        stall          = (|ofmap_valid) & ~ofmap_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_vec_d = cfg_num_vec;
                    issue_d   = '0;
                    load_d    = '0;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                if (load_q < LW'(ROWS)) begin
                    weight_rd_en   = 1'b1;
                    weight_rd_addr = AW'(load_q);
                    wen_d          = ROWS'(1) << load_q;
                    load_d         = load_q + LW'(1);
                end
                // Last row's write lands one cycle after its read.
                if (wen_q[ROWS-1]) begin
                    state_d = (num_vec_q == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                mac_en      = ifmap_valid & ~stall & (issue_q != num_vec_q);
                ifmap_ready = mac_en;
                issue       = mac_en;
                if (mac_en) begin
                    issue_d = issue_q + COUNT_WIDTH'(1);
                    if (issue_d == num_vec_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ifmap_zero = 1'b1;
                mac_en     = ~stall;
                line_next  = mac_en ? (line << 1) : line;
                if (line_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_vec_q <= '0;
            issue_q   <= '0;
            load_q    <= '0;
            wen_q     <= '0;
        end else begin
            state_q   <= state_d;
            num_vec_q <= num_vec_d;
            issue_q   <= issue_d;
            load_q    <= load_d;
            wen_q     <= wen_d;
        end
    end

    valid_skew_pipe #(
        .DEPTH (DEPTH)
    ) u_skew (
        .clk (clk),
        .rst (rst),
        .en  (mac_en),
        .din (issue),
        .q   (line)
    );

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign weight_wen  = wen_q;
    assign ofmap_valid = line[ROWS-1 +: COLS];

endmodule

// File: doc/systolic_array_controller.md
SYSTOLIC_ARRAY_CONTROLLER -- requirements
Module: systolic_array_controller

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning MAC rows (weight rows, ifmap lanes).
REQ-002 SHALL have parameter COLS, default 4, meaning MAC columns (ofmap lanes).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the vector counter.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle job request, sampled in IDLE only.
REQ-007 SHALL have port cfg_num_vec  in  COUNT_WIDTH  number of ifmap vectors, captured on accepted start.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-010 SHALL have port weight_rd_en  out  1  weight buffer read strobe (1-cycle read latency).
REQ-011 SHALL have port weight_rd_addr  out  clog2(ROWS)  weight row being read.
REQ-012 SHALL have port weight_wen  out  ROWS  one-hot row weight-write enable to the array.
REQ-013 SHALL have port ifmap_valid  in  1  input buffer has a vector.
REQ-014 SHALL have port ifmap_ready  out  1  pop of one ifmap vector.
REQ-015 SHALL have port ifmap_zero  out  1  array ifmap mux drives zeros (drain bubble).
REQ-016 SHALL have port mac_en  out  1  array-wide MAC register enable.
REQ-017 SHALL have port ofmap_valid  out  COLS  per-column result valid at array bottom.
REQ-018 SHALL have port ofmap_ready  in  1  output sink accepts all asserted columns.

Function
REQ-019 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-020 IDLE with start=1 SHALL capture cfg_num_vec, clear counters, and enter LOAD_W next cycle; start outside IDLE SHALL be ignored.
REQ-021 LOAD_W SHALL assert weight_rd_en for exactly ROWS consecutive cycles with weight_rd_addr 0..ROWS-1.
REQ-022 weight_wen bit r SHALL be high exactly in the cycle after weight_rd_addr=r was read; never more than one bit high.
REQ-023 The cycle after weight_wen[ROWS-1] SHALL enter STREAM, or DONE if captured count is 0.
REQ-024 stall SHALL be defined as (ofmap_valid & ~ofmap_ready) nonzero; mac_en SHALL be 0 whenever stall=1.
REQ-025 In STREAM, mac_en=ifmap_ready=(ifmap_valid & ~stall); each such cycle issues one vector and increments the issue count.
REQ-026 In STREAM with ifmap_valid=0 the array SHALL freeze (mac_en=0), no bubble inserted.
REQ-027 The cycle the issue count reaches cfg_num_vec SHALL be followed by DRAIN.
REQ-028 In DRAIN, ifmap_zero=1, ifmap_ready=0, mac_en=~stall.
REQ-029 A delay line of ROWS+COLS-1 stages SHALL advance only when mac_en=1, inserting 1 for an issued vector and 0 otherwise.
REQ-030 ofmap_valid[c] SHALL equal delay-line stage ROWS-1+c (vector issued ROWS+c enabled cycles earlier).
REQ-031 DRAIN SHALL exit to DONE the cycle the delay line becomes all-zero.
REQ-032 DONE SHALL assert done for one cycle and return to IDLE; busy=0 in that IDLE cycle.
REQ-033 Issue count SHALL saturate at cfg_num_vec; no wrap.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE, clear counters and delay line; all outputs 0.
REQ-035 rst mid-job SHALL abandon the job; no done pulse is generated for it.

Structure
REQ-036 State enum and stage-count helper SHALL live in shared package systolic_pkg.
REQ-037 The enable-gated delay line SHALL be sub-module valid_skew_pipe (params DEPTH; ports clk, rst, en, din, q[DEPTH-1:0]).

Verification (ROWS=COLS=4)
REQ-038 start, num_vec=3, ifmap_valid=1, ofmap_ready=1 -> weight_wen 0001,0010,0100,1000 on cycles 2-5; 3 ifmap_ready pulses; ofmap_valid[0] first high 4 mac_en cycles after first issue; done after 10 total mac_en cycles.
REQ-039 num_vec=0 -> LOAD_W of 4 cycles, then done; mac_en never asserted.
REQ-040 ifmap_valid toggling 1,0,1,0 in STREAM -> mac_en mirrors it; ofmap_valid pattern identical to unstalled run counted in enabled cycles.
REQ-041 ofmap_ready=0 for 3 cycles while ofmap_valid[2]=1 -> mac_en=0, ifmap_ready=0, ofmap_valid held for 3 cycles, then resumes.
REQ-042 rst asserted mid-STREAM -> outputs 0 same cycle, busy=0, no done; new start completes normally.
REQ-043 start pulsed while busy -> ignored; exactly one done.
